// File: rtl/div_if.sv
// Request/response bundle between the control path and the RV32M divide unit.
// The requester drives the operation; the divider answers with status and write-back.
interface div_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      Funct3;
    logic [4:0]      Rd_in;
    logic [XLEN-1:0] Operand_a;
    logic [XLEN-1:0] Operand_b;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic [4:0]      Rd_out;
    logic            RegWrite_out;

    modport master (
        output Start, Funct3, Rd_in, Operand_a, Operand_b,
        input  Busy, Done, Result, Rd_out, RegWrite_out
    );

    modport slave (
        input  Start, Funct3, Rd_in, Operand_a, Operand_b,
        output Busy, Done, Result, Rd_out, RegWrite_out
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with a one-cycle write-back pulse into the register file.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  reset_n,
    div_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op_rem, neg_q, neg_r;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] divisor, rem, quo;

    logic            busy_r, done_r, regwrite_r;
    logic [XLEN-1:0] result_r;
    logic [4:0]      rd_out_r;

    // Decode of the request presented in IDLE
    logic            accept, is_signed, a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, sp_res;

    always_comb begin
        accept    = (state == IDLE) && bus.Start && bus.Funct3[2];
        is_signed = ~bus.Funct3[0];
        a_neg     = is_signed & bus.Operand_a[XLEN-1];
        b_neg     = is_signed & bus.Operand_b[XLEN-1];
        a_mag     = a_neg ? -bus.Operand_a : bus.Operand_a;
        b_mag     = b_neg ? -bus.Operand_b : bus.Operand_b;
        div_zero  = (bus.Operand_b == '0);
        ovf       = is_signed && (bus.Operand_a == INT_MIN) && (&bus.Operand_b);
        special   = div_zero | ovf;
        if (div_zero)
            sp_res = bus.Funct3[1] ? bus.Operand_a : '1;
        else
            sp_res = bus.Funct3[1] ? '0 : INT_MIN;
    end

    // One restoring step. The trial compare uses the full XLEN+1-bit shifted
    // remainder; when it succeeds the true difference always fits in XLEN bits,
    // so the low-XLEN subtraction is exact.
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff_lo, new_rem, new_quo, fin_q, fin_r;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        ge      = (shifted >= {1'b0, divisor});
        diff_lo = shifted[XLEN-1:0] - divisor;
        new_rem = ge ? diff_lo : shifted[XLEN-1:0];
        new_quo = {quo[XLEN-2:0], ge};
        fin_q   = neg_q ? -new_quo : new_quo;
        fin_r   = neg_r ? -new_rem : new_rem;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            rd_q       <= '0;
            divisor    <= '0;
            rem        <= '0;
            quo        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            regwrite_r <= 1'b0;
            result_r   <= '0;
            rd_out_r   <= '0;
        end else begin
            done_r     <= 1'b0;
            regwrite_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_rem  <= bus.Funct3[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        rd_q    <= bus.Rd_in;
                        divisor <= b_mag;
                        rem     <= '0;
                        quo     <= a_mag;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        if (special) begin
                            state      <= DONE;
                            result_r   <= sp_res;
                            rd_out_r   <= bus.Rd_in;
                            done_r     <= 1'b1;
                            regwrite_r <= |bus.Rd_in;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= new_rem;
                    quo <= new_quo;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN-1)) begin
                        state      <= DONE;
                        result_r   <= op_rem ? fin_r : fin_q;
                        rd_out_r   <= rd_q;
                        done_r     <= 1'b1;
                        regwrite_r <= |rd_q;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy         = busy_r;
    assign bus.Done         = done_r;
    assign bus.RegWrite_out = regwrite_r;
    assign bus.Result       = result_r;
    assign bus.Rd_out       = rd_out_r;
endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a plain-arithmetic RV32M model.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'd0 : 32'h8000_0000;
        if (!f3[0]) begin
            if (f3[1]) return sa % sb;
            return sa / sb;
        end
        if (f3[1]) return a % b;
        return a / b;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op and follow it to completion; poke=1 also pulses Start in CALC and DONE.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit poke);
        int k, busy_n, extra;
        bit seen;
        logic [31:0] exp;
        int lat;
        exp = ref_div(f3, a, b);
        lat = ref_lat(f3, a, b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = f3; bus.Rd_in = rd;
        bus.Operand_a = a; bus.Operand_b = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Operand_a = $urandom; bus.Operand_b = $urandom; bus.Rd_in = 5'($urandom);
        k = 0; busy_n = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.Busy) busy_n++;
            if (poke) bus.Start = (k == 5);
            if (bus.Done) seen = 1;
        end
        chk({tag, ":latency"}, k, lat);
        chk({tag, ":result"}, bus.Result, exp);
        chk({tag, ":rd_out"}, bus.Rd_out, rd);
        chk({tag, ":regwrite"}, bus.RegWrite_out, (rd != 5'd0));
        chk({tag, ":busy_cycles"}, busy_n, lat);
        if (poke) bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        chk({tag, ":idle_busy"}, bus.Busy, 1'b0);
        chk({tag, ":idle_done"}, bus.Done, 1'b0);
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.Done || bus.Busy) extra++;
            end
            chk({tag, ":ignored_start"}, extra, 0);
            chk({tag, ":result_held"}, bus.Result, exp);
        end
    endtask

    initial begin
        int cnt;
        logic [2:0]  f3;
        logic [31:0] a, b;
        bus.Start = 1'b0; bus.Funct3 = 3'b000; bus.Rd_in = 5'd0;
        bus.Operand_a = '0; bus.Operand_b = '0;
        #12;
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_regwrite", bus.RegWrite_out, 1'b0);
        chk("rst_result", bus.Result, 32'd0);
        chk("rst_rd_out", bus.Rd_out, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 1'b0);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        do_op("div_by0",    3'b100, 32'd42, 32'd0, 5'd6, 1'b0);
        do_op("remu_by0",   3'b111, 32'd42, 32'd0, 5'd7, 1'b0);
        do_op("rem_by0_neg",3'b110, 32'hFFFF_FF00, 32'd0, 5'd8, 1'b0);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        do_op("divu_big",   3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd11, 1'b0);
        do_op("poke",       3'b101, 32'd1000, 32'd9, 5'd12, 1'b1);
        do_op("rd_zero",    3'b111, 32'd77, 32'd10, 5'd0, 1'b0);

        // Reset during CALC abandons the op without write-back
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = 3'b101; bus.Rd_in = 5'd13;
        bus.Operand_a = 32'd1000; bus.Operand_b = 32'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", bus.Busy, 1'b0);
        chk("midrst_done", bus.Done, 1'b0);
        chk("midrst_regwrite", bus.RegWrite_out, 1'b0);
        chk("midrst_result", bus.Result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done || bus.RegWrite_out || bus.Busy) cnt++;
        end
        chk("midrst_no_wb", cnt, 0);
        do_op("after_rst_9_3", 3'b101, 32'd9, 32'd3, 5'd14, 1'b0);

        // Non-divide Funct3 must not start the unit
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = 3'b000; bus.Operand_a = 32'd5; bus.Operand_b = 32'd1;
        @(negedge clk);
        bus.Start = 1'b0;
        cnt = 0;
        repeat (5) begin
            if (bus.Busy || bus.Done) cnt++;
            @(negedge clk);
        end
        chk("f3_000_ignored", cnt, 0);

        for (int i = 0; i < 40; i++) begin
            f3 = {1'b1, 2'($urandom)};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
